mux_serialiser: RTL and testbench

MUX_SERIALISER -- requirements
Module: mux_serialiser

---
 rtl/mux_ser_pkg.sv | 24 ++
 rtl/sel_counter.sv | 38 +++
 rtl/mux_serialiser.sv | 135 +++++++++++++
 tb/tb_mux_serialiser.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_ser_pkg.sv
// ============================================================================
// Package     : mux_ser_pkg
// Description : Shared state encoding and default word width for mux_serialiser.
//               PAR_BIT_EN adds the PARITY state to the encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mux_ser_pkg;

    localparam int c_DEFAULT_N = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
`ifdef PAR_BIT_EN
        ST_PARITY = 2'd2,
`endif
        ST_DONE   = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/sel_counter.sv
// ============================================================================
// Module      : sel_counter
// Description : Select-line counter with synchronous clear, enable and a
//               terminal-count flag raised at the all-ones value.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sel_counter
    import mux_ser_pkg::*;
#(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_count,
    output logic             o_tc
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    // The mux width is a power of two, so the last index is all ones.
    assign o_count = r_count;
    assign o_tc    = &r_count;

endmodule

`default_nettype wire

// File: rtl/mux_serialiser.sv
// ============================================================================
// Module      : mux_serialiser
// Description : Holds a word on an external N:1 mux and walks its select line
//               to emit the word MSB-first over a valid/ready bit stream.
//               Define PAR_BIT_EN to append one even-parity bit per word.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux_serialiser
    import mux_ser_pkg::*;
#(
    parameter int N     = c_DEFAULT_N,
    parameter int SEL_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [N-1:0]     load_data,
    output logic [N-1:0]     x,
    output logic [SEL_W-1:0] ss,
    input  logic             y,
    output logic             bit_out,
    output logic             bit_valid,
    input  logic             bit_ready,
    output logic             done
);

    state_t           r_state;
    state_t           w_next_state;
    logic [N-1:0]     r_x;
    logic             w_cnt_en;
    logic             w_cnt_clear;
    logic             w_tc;

    sel_counter #(
        .WIDTH (SEL_W)
    ) u_sel_counter (
        .clk     (clk),
        .rst     (reset),
        .i_clear (w_cnt_clear),
        .i_en    (w_cnt_en),
        .o_count (ss),
        .o_tc    (w_tc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // The held word only changes on an accepted load, so y stays stable while stalled.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_x <= '0;
        end else if (r_state == ST_IDLE && load_valid) begin
            r_x <= load_data;
        end
    end

    assign x = r_x;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (load_valid) begin
                    w_next_state = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (bit_ready && w_tc) begin
`ifdef PAR_BIT_EN
                    w_next_state = ST_PARITY;
`else
                    w_next_state = ST_DONE;
`endif
                end
            end
`ifdef PAR_BIT_EN
            ST_PARITY: begin
                if (bit_ready) begin
                    w_next_state = ST_DONE;
                end
            end
`endif
            ST_DONE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        load_ready  = 1'b0;
        bit_valid   = 1'b0;
        bit_out     = 1'b0;
        done        = 1'b0;
        w_cnt_en    = 1'b0;
        w_cnt_clear = 1'b0;
        case (r_state)
            ST_IDLE: begin
                load_ready = 1'b1;
            end
            ST_SHIFT: begin
                bit_valid = 1'b1;
                bit_out   = y;
                // Gated at terminal count so ss parks on the last index.
                w_cnt_en  = bit_ready && !w_tc;
            end
`ifdef PAR_BIT_EN
            ST_PARITY: begin
                bit_valid = 1'b1;
                bit_out   = ^r_x;
            end
`endif
            ST_DONE: begin
                done        = 1'b1;
                w_cnt_clear = 1'b1;
            end
            default: begin
                load_ready = 1'b0;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_mux_serialiser.sv
// ============================================================================
// Module      : tb_mux_serialiser
// Description : Scoreboard bench for mux_serialiser with a behavioural N:1 mux
//               (ss=0 selects x[N-1]); follows PAR_BIT_EN like the design.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mux_serialiser;

    localparam int N     = 8;
    localparam int SEL_W = 3;
`ifdef PAR_BIT_EN
    localparam int BITS  = N + 1;
`else
    localparam int BITS  = N;
`endif

    logic             clk;
    logic             reset;
    logic             load_valid;
    logic             load_ready;
    logic [N-1:0]     load_data;
    logic [N-1:0]     x;
    logic [SEL_W-1:0] ss;
    logic             y;
    logic             bit_out;
    logic             bit_valid;
    logic             bit_ready;
    logic             done;

    mux_serialiser #(
        .N     (N),
        .SEL_W (SEL_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .x          (x),
        .ss         (ss),
        .y          (y),
        .bit_out    (bit_out),
        .bit_valid  (bit_valid),
        .bit_ready  (bit_ready),
        .done       (done)
    );

    assign y = x[(N-1) - int'(ss)];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic             b;
        logic [SEL_W-1:0] s;
        logic             last;
    } exp_t;

    exp_t sb[$];
    int   checks     = 0;
    int   passes     = 0;
    int   acc_count  = 0;
    int   tick_count = 0;
    int   acc_tick   = 0;
    bit   rand_rdy   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Expected stream for a word: data MSB first at ss 0..N-1, then the parity bit.
    task automatic push_word(input logic [N-1:0] d);
        for (int i = 0; i < N; i++) begin
            sb.push_back('{d[N-1-i], SEL_W'(i), logic'((i == N-1) && (BITS == N))});
        end
`ifdef PAR_BIT_EN
        sb.push_back('{logic'($countones(d) % 2), SEL_W'(N-1), 1'b1});
`endif
    endtask

    task automatic tick();
        bit           acc;
        logic [N-1:0] d;
        @(negedge clk);
        acc = load_valid && load_ready && !reset;
        d   = load_data;
        @(posedge clk);
        tick_count++;
        if (acc) begin
            push_word(d);
            acc_count++;
            acc_tick = tick_count;
        end
        #1;
        if (rand_rdy) bit_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send_word(input logic [N-1:0] d);
        int  n;
        bit  ok;
        n          = acc_count;
        ok         = 1'b0;
        load_valid = 1'b1;
        load_data  = d;
        for (int i = 0; i < 400 && !ok; i++) begin
            tick();
            ok = (acc_count != n);
        end
        if (!ok) check("load_accept_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            if (load_ready === 1'b1 && sb.size() == 0) ok = 1'b1;
            else tick();
        end
        if (!ok) check("idle_timeout", 0, 1);
    endtask

    task automatic wait_ss(input logic [SEL_W-1:0] v);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            if (ss === v) ok = 1'b1;
            else tick();
        end
        if (!ok) check("ss_reach_timeout", 0, 1);
    endtask

    // Monitor: compares DUT outputs against the scoreboard on every falling edge.
    initial begin
        bit prev_rst;
        bit done_next;
        bit exp_done;
        prev_rst  = 1'b0;
        done_next = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                sb.delete();
                done_next = 1'b0;
                prev_rst  = 1'b1;
            end else begin
                if (prev_rst) begin
                    check("rst_x", 32'(x), 0);
                    check("rst_ss", 32'(ss), 0);
                    check("rst_load_ready", 32'(load_ready), 1);
                    check("rst_bit_valid", 32'(bit_valid), 0);
                end
                prev_rst  = 1'b0;
                exp_done  = done_next;
                done_next = 1'b0;
                check("done", 32'(done), 32'(exp_done));
                check("load_ready", 32'(load_ready), 32'(sb.size() == 0 && !exp_done));
                check("bit_valid", 32'(bit_valid), 32'(sb.size() != 0));
                if (sb.size() != 0) begin
                    check("bit_out", 32'(bit_out), 32'(sb[0].b));
                    check("ss", 32'(ss), 32'(sb[0].s));
                    if (bit_valid && bit_ready) begin
                        if (sb[0].last) done_next = 1'b1;
                        void'(sb.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        int first;
        reset      = 1'b1;
        load_valid = 1'b0;
        load_data  = '0;
        bit_ready  = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        send_word(8'b10101100);
        load_valid = 1'b0;
        wait_idle();

        // Three-cycle stall with ss parked at 4.
        send_word(8'b10101100);
        load_valid = 1'b0;
        wait_ss(3'd4);
        bit_ready = 1'b0;
        repeat (3) tick();
        bit_ready = 1'b1;
        wait_idle();

        // load_valid stays high with new data while the first word shifts out.
        send_word(8'b10101100);
        send_word(8'hFF);
        load_valid = 1'b0;
        wait_idle();

        send_word(8'h00);
        first = acc_tick;
        send_word(8'hFF);
        check("b2b_accept_gap", 32'(acc_tick - first), 32'(BITS + 2));
        load_valid = 1'b0;
        wait_idle();

        send_word(8'b10101101);
        load_valid = 1'b0;
        wait_idle();

        // Reset mid-word abandons it; the following word must still be correct.
        send_word(8'b10101100);
        load_valid = 1'b0;
        wait_ss(3'd3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        send_word(8'b10101100);
        load_valid = 1'b0;
        wait_idle();

        rand_rdy = 1'b1;
        repeat (20) begin
            repeat ($urandom_range(0, 3)) tick();
            send_word(N'($urandom));
            load_valid = 1'b0;
        end
        wait_idle();
        rand_rdy  = 1'b0;
        bit_ready = 1'b1;
        repeat (3) tick();
        check("scoreboard_drained", 32'(sb.size()), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

`default_nettype wire
